rv_mem_responder: RTL and testbench

// - Memory-side responder for the multicycle RISC-V core: word-addressed data RAM behind a req/ready handshake.
// - Services one load or store at a time, with programmable wait states.
// - Sits between the core's memory request signals (address, write enable, write data) and the core's MDR/ready inputs.
// - Flags misaligned and out-of-range accesses instead of completing them.

---
 rtl/rv_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_rv_mem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_responder.sv
// rv_mem_responder
// Memory-side responder for the multicycle RISC-V core. It holds a
// word-addressed data RAM behind a req/ready handshake and services one
// load or store at a time, with LATENCY programmable wait states.
// Misaligned or out-of-range accesses are flagged through err and are
// not performed.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_i      request valid; the requester holds it until ready_o
//   we_i       1 = store, 0 = load
//   addr_i     byte address
//   wdata_i    store data
//   wstrb_i    store byte enables; bit i enables wdata_i[8i+7:8i]
//   rdata_o    load data; valid while ready_o=1, otherwise holds its value
//   ready_o    one-cycle completion pulse
//   err_o      access error; only ever 1 together with ready_o
//   busy_o     1 whenever a transaction is in flight
//
// States
//   S_IDLE   | waiting for req_i; captures the request on acceptance
//   S_WAIT   | burning LATENCY wait cycles on the down-counter
//   S_ACCESS | checks the captured address, reads or writes the RAM
//   S_DONE   | ready_o pulse, then back to S_IDLE
module rv_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        capture;
  logic        access;
  logic        acc_err;
  logic [ADDR_W-1:0] word_idx;

  logic [31:0] mem [DEPTH];

  // The address check only looks at the captured copy, so input activity
  // after acceptance cannot influence the response.
  assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
  assign word_idx = addr_q[ADDR_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    ready_o = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (req_i) begin
          capture = 1'b1;
          cnt_d   = LAT4;
          state_d = (LATENCY == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        access  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        ready_o = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      if (access) begin
        err_q <= acc_err;
        // Error responses zero rdata for loads and stores alike; a good
        // store leaves the last loaded value in place.
        if (acc_err) begin
          rdata_q <= 32'd0;
        end else if (!we_q) begin
          rdata_q <= mem[word_idx];
        end
      end else if (state_q == S_DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  // RAM is deliberately left out of reset. An aborted transaction never
  // reaches S_ACCESS, so reset mid-flight cannot commit a write.
  always_ff @(posedge clk) begin
    if (access && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
module tb_rv_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NI     = 3;
  localparam int LATS [NI] = '{2, 0, 5};

  logic        clk;
  logic        rst;
  logic        we_s;
  logic [31:0] addr_s;
  logic [31:0] wdata_s;
  logic [3:0]  wstrb_s;
  logic        req   [NI];
  logic [31:0] rdata [NI];
  logic        ready [NI];
  logic        err   [NI];
  logic        busy  [NI];

  int total = 0;
  int bad   = 0;

  // Reference model: one word array and one "last rdata" per instance.
  bit [31:0] mem_m [NI][DEPTH];
  bit [31:0] rd_m  [NI];

  rv_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we_s), .addr_i(addr_s),
    .wdata_i(wdata_s), .wstrb_i(wstrb_s), .rdata_o(rdata[0]),
    .ready_o(ready[0]), .err_o(err[0]), .busy_o(busy[0]));

  rv_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we_s), .addr_i(addr_s),
    .wdata_i(wdata_s), .wstrb_i(wstrb_s), .rdata_o(rdata[1]),
    .ready_o(ready[1]), .err_o(err[1]), .busy_o(busy[1]));

  rv_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(5)) dut2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we_s), .addr_i(addr_s),
    .wdata_i(wdata_s), .wstrb_i(wstrb_s), .rdata_o(rdata[2]),
    .ready_o(ready[2]), .err_o(err[2]), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of one transaction from the functional rules: error check,
  // byte-lane merge for stores, word fetch for loads.
  task automatic mdl(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] exp_rd, output logic exp_err);
    bit e;
    int idx;
    e   = (a % 4 != 0) || ((a >> (ADDR_W + 2)) != 0);
    idx = int'(a / 4) % DEPTH;
    if (e) begin
      rd_m[k] = 32'd0;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (st[i]) mem_m[k][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      rd_m[k] = mem_m[k][idx];
    end
    exp_rd  = rd_m[k];
    exp_err = e;
  endtask

  // Issue one request on instance k and wait for its ready pulse. Checks
  // latency, busy through the transaction and that ready is one cycle wide.
  task automatic run(input int k, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input bit scr,
                     output logic [31:0] rd, output logic e);
    int n;
    bit bok;
    bit seen;
    @(negedge clk);
    we_s = w; addr_s = a; wdata_s = wd; wstrb_s = st; req[k] = 1'b1;
    @(posedge clk); #1;
    n = 0; bok = 1'b1; seen = 1'b0;
    if (busy[k] !== 1'b1) bok = 1'b0;
    while (!seen && n < 40) begin
      if (scr) begin
        req[k]  = 1'($urandom_range(0, 1));
        addr_s  = $urandom;
        wdata_s = $urandom;
        we_s    = 1'($urandom_range(0, 1));
        wstrb_s = 4'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (busy[k] !== 1'b1) bok = 1'b0;
      if (ready[k] === 1'b1) seen = 1'b1;
    end
    req[k] = 1'b0;
    rd = rdata[k];
    e  = err[k];
    chk("ready_seen", 32'(seen), 32'd1);
    chk("latency", n, LATS[k] + 1);
    chk("busy_held", 32'(bok), 32'd1);
    @(posedge clk); #1;
    chk("single_pulse_idle", {30'd0, ready[k], busy[k]}, 32'd0);
  endtask

  task automatic run_m(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input bit scr);
    logic [31:0] rd, erd;
    logic        e, ee;
    run(k, w, a, wd, st, scr, rd, e);
    mdl(k, w, a, wd, st, erd, ee);
    chk("model_rdata", rd, erd);
    chk("model_err", 32'(e), 32'(ee));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] rd, erd;
    logic        e, ee;
    logic [31:0] pool [8];
    int          rcount;

    pool = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h40, 32'h7C, 32'hFFC, 32'h800};

    rst = 1'b1;
    we_s = 1'b0; addr_s = 32'd0; wdata_s = 32'd0; wstrb_s = 4'd0;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0;
      rd_m[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      chk("reset_outputs", {rdata[k][29:0], ready[k], err[k]} | {30'd0, busy[k], 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the LATENCY=2 instance.
    vt.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0});
    vt.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 32'h20,       32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    vt.push_back('{1'b1, 32'h0,        32'h5A5A5A5A, 4'hF, 32'h11BB33DD, 1'b0});
    vt.push_back('{1'b0, 32'h13,       32'h0,        4'h0, 32'h00000000, 1'b1});
    vt.push_back('{1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1});
    vt.push_back('{1'b0, 32'h0,        32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
    vt.push_back('{1'b1, 32'h12,       32'h00000000, 4'hF, 32'h00000000, 1'b1});
    vt.push_back('{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 32'h20,       32'h99999999, 4'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0});
    vt.push_back('{1'b0, 32'h80000000, 32'h0,        4'h0, 32'h00000000, 1'b1});

    foreach (vt[i]) begin
      run(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, 1'b0, rd, e);
      mdl(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, erd, ee);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
    end

    // Latency sweep on LATENCY=0 and LATENCY=5 instances.
    for (int k = 1; k < NI; k++) begin
      run_m(k, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0);
      run_m(k, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      run_m(k, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    end

    // Ignored request: inputs scrambled while busy, response must follow
    // the captured store and a later load.
    run_m(0, 1'b1, 32'h7C, 32'hC0FFEE11, 4'hF, 1'b1);
    run_m(0, 1'b0, 32'h7C, 32'h0, 4'h0, 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < NI; k++)
      foreach (pool[p]) run_m(k, 1'b1, pool[p], $urandom, 4'hF, 1'b0);
    for (int t = 0; t < 80; t++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, NI - 1);
      a = pool[$urandom_range(0, 7)];
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | 32'h1000 << $urandom_range(0, 19);
        default: ;
      endcase
      run_m(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
            1'($urandom_range(0, 1)));
    end

    // Reset mid-transaction on a store to 0x40 holding 0x0.
    run_m(0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    we_s = 1'b1; addr_s = 32'h40; wdata_s = 32'hCAFEF00D; wstrb_s = 4'hF; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("abort_in_wait_busy", 32'(busy[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {rdata[0][28:0], ready[0], err[0], busy[0]}, 32'd0);
    chk("abort_rdata", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NI; k++) rd_m[k] = 32'd0;
    rcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[0] === 1'b1 || busy[0] === 1'b1) rcount++;
    end
    chk("abort_no_ready", rcount, 0);
    run_m(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    run(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, e);
    chk("abort_reread_0x40", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
